// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the SS.hh BCD countdown timer.
// Holds the state encoding, the BCD ceiling and the load clamp.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Keys can present non-BCD codes; anything above 9 is pinned to 9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] value);
        return (value > BCD_MAX) ? BCD_MAX : value;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD digit of the countdown value: loadable, decrements on borrow_in,
// and wraps 0 -> 9 while passing the borrow to the next more significant digit.
module bcd_down_digit
    import countdown_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out,
    output logic       is_zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= bcd_clamp(load_val);
        end else if (borrow_in) begin
            digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
        end
    end

    assign is_zero    = (digit == 4'd0);
    assign borrow_out = borrow_in && is_zero;

endmodule

// File: rtl/countdown_timer.sv
// SS.hh BCD countdown timer: loads a preset, counts down one hundredth per
// TICKS_PER_DIGIT enables while running, and flags expiry at 00.00.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 10,
    parameter int PRESCALE_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       load,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    input  logic [3:0] load_ms_hundreds,
    input  logic [3:0] load_ms_tens,
    input  logic       start_pause,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] ms_hundreds,
    output logic [3:0] ms_tens,
    output logic       running,
    output logic       expired,
    output logic       done_pulse
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICKS_PER_DIGIT - 1);

    state_t                state;
    state_t                next_state;
    logic [PRESCALE_W-1:0] prescaler;
    logic                  running_d;
    logic                  expired_d;
    logic                  done_d;

    logic [4:0] borrow;
    logic       zero_sec_tens;
    logic       zero_sec_ones;
    logic       zero_ms_hundreds;
    logic       zero_ms_tens;
    logic       value_zero;
    logic       terminal_tick;
    logic       dec;
    logic       last_step;
    logic       unused_borrow;

    assign value_zero    = zero_sec_tens && zero_sec_ones && zero_ms_hundreds && zero_ms_tens;
    assign terminal_tick = (state == RUN) && tick_en && (prescaler == PRESCALE_LAST);
    assign dec           = terminal_tick && !load && !value_zero;
    // A decrement from 00.01 is the only one that lands on 00.00.
    assign last_step     = dec && zero_sec_tens && zero_sec_ones && zero_ms_hundreds
                           && (ms_tens == 4'd1);

    assign borrow[0]     = dec;
    assign unused_borrow = borrow[4];

    bcd_down_digit u_ms_tens (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_ms_tens),
        .borrow_in  (borrow[0]),
        .digit      (ms_tens),
        .borrow_out (borrow[1]),
        .is_zero    (zero_ms_tens)
    );

    bcd_down_digit u_ms_hundreds (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_ms_hundreds),
        .borrow_in  (borrow[1]),
        .digit      (ms_hundreds),
        .borrow_out (borrow[2]),
        .is_zero    (zero_ms_hundreds)
    );

    bcd_down_digit u_sec_ones (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_sec_ones),
        .borrow_in  (borrow[2]),
        .digit      (sec_ones),
        .borrow_out (borrow[3]),
        .is_zero    (zero_sec_ones)
    );

    bcd_down_digit u_sec_tens (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_sec_tens),
        .borrow_in  (borrow[3]),
        .digit      (sec_tens),
        .borrow_out (borrow[4]),
        .is_zero    (zero_sec_tens)
    );

    // Prescaler only advances in RUN, so a partial count survives a pause.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else if (load || last_step) begin
            prescaler <= '0;
        end else if ((state == RUN) && tick_en) begin
            prescaler <= terminal_tick ? '0 : prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            running    <= 1'b0;
            expired    <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= next_state;
            running    <= running_d;
            expired    <= expired_d;
            done_pulse <= done_d;
        end
    end

    always_comb begin
        next_state = state;
        if (load) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_pause && !value_zero) next_state = RUN;
                RUN: begin
                    // Expiry outranks a coincident pause request.
                    if (last_step)        next_state = EXPIRED;
                    else if (start_pause) next_state = PAUSE;
                end
                PAUSE:   if (start_pause) next_state = RUN;
                EXPIRED: next_state = EXPIRED;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        running_d = (next_state == RUN);
        expired_d = (next_state == EXPIRED);
        done_d    = (next_state == EXPIRED) && (state != EXPIRED);
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: each scenario queues expected
// digit/flag snapshots and compares them against captured DUT outputs.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_en;
    logic       load;
    logic [3:0] load_sec_tens;
    logic [3:0] load_sec_ones;
    logic [3:0] load_ms_hundreds;
    logic [3:0] load_ms_tens;
    logic       start_pause;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] ms_hundreds;
    logic [3:0] ms_tens;
    logic       running;
    logic       expired;
    logic       done_pulse;

    typedef struct {
        string       name;
        logic [18:0] value;
    } exp_t;

    exp_t        exp_q[$];
    logic [18:0] obs_q[$];
    int          compared   = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    countdown_timer #(
        .TICKS_PER_DIGIT (10),
        .PRESCALE_W      (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tick_en          (tick_en),
        .load             (load),
        .load_sec_tens    (load_sec_tens),
        .load_sec_ones    (load_sec_ones),
        .load_ms_hundreds (load_ms_hundreds),
        .load_ms_tens     (load_ms_tens),
        .start_pause      (start_pause),
        .sec_tens         (sec_tens),
        .sec_ones         (sec_ones),
        .ms_hundreds      (ms_hundreds),
        .ms_tens          (ms_tens),
        .running          (running),
        .expired          (expired),
        .done_pulse       (done_pulse)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called at a negedge: holds the controls for one posedge, then releases them.
    task automatic cycle(input logic l, input logic s, input logic t, input logic r);
        load        = l;
        start_pause = s;
        tick_en     = t;
        rst         = r;
        @(negedge clk);
        load        = 1'b0;
        start_pause = 1'b0;
        tick_en     = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic preset(input logic [15:0] v);
        load_sec_tens    = v[15:12];
        load_sec_ones    = v[11:8];
        load_ms_hundreds = v[7:4];
        load_ms_tens     = v[3:0];
    endtask

    task automatic sb_push(input string name, input logic [15:0] digits,
                           input logic r, input logic e, input logic d);
        exp_q.push_back('{name, {digits, r, e, d}});
    endtask

    task automatic observe();
        obs_q.push_back({sec_tens, sec_ones, ms_hundreds, ms_tens, running, expired, done_pulse});
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [18:0] o;
        sb_push("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        observe();
        preset(16'h1234);
        sb_push("load_1234", 16'h1234, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        observe();
        sb_push("idle_no_decrement", 16'h1234, 1'b0, 1'b0, 1'b0);
        ticks(50);
        observe();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'bx;
            compared++;
            if (o !== e.value) begin
                mismatched++;
                $display("[TB] FAIL %s: got digits=%h flags=%b expected digits=%h flags=%b",
                         e.name, o[18:3], o[2:0], e.value[18:3], e.value[2:0]);
            end
        end
    endtask

    task automatic test_expiry();
        exp_t        e;
        logic [18:0] o;
        preset(16'h0005);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        sb_push("expiry_start", 16'h0005, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        observe();
        sb_push("expiry_tick49", 16'h0001, 1'b1, 1'b0, 1'b0);
        ticks(49);
        observe();
        sb_push("expiry_tick50", 16'h0000, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        observe();
        sb_push("done_pulse_single", 16'h0000, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        observe();
        sb_push("expired_ignores_inputs", 16'h0000, 1'b0, 1'b1, 1'b0);
        ticks(20);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        observe();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'bx;
            compared++;
            if (o !== e.value) begin
                mismatched++;
                $display("[TB] FAIL %s: got digits=%h flags=%b expected digits=%h flags=%b",
                         e.name, o[18:3], o[2:0], e.value[18:3], e.value[2:0]);
            end
        end
    endtask

    task automatic test_borrow_chain();
        exp_t        e;
        logic [18:0] o;
        preset(16'h1000);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        sb_push("borrow_tick9", 16'h1000, 1'b1, 1'b0, 1'b0);
        ticks(9);
        observe();
        sb_push("borrow_full_chain", 16'h0999, 1'b1, 1'b0, 1'b0);
        ticks(1);
        observe();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'bx;
            compared++;
            if (o !== e.value) begin
                mismatched++;
                $display("[TB] FAIL %s: got digits=%h flags=%b expected digits=%h flags=%b",
                         e.name, o[18:3], o[2:0], e.value[18:3], e.value[2:0]);
            end
        end
    endtask

    task automatic test_pause_resume();
        exp_t        e;
        logic [18:0] o;
        preset(16'h0020);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        sb_push("pause_run7", 16'h0020, 1'b1, 1'b0, 1'b0);
        ticks(7);
        observe();
        sb_push("pause_enter", 16'h0020, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        observe();
        sb_push("pause_hold", 16'h0020, 1'b0, 1'b0, 1'b0);
        ticks(20);
        observe();
        sb_push("resume_run", 16'h0020, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        observe();
        sb_push("resume_tick2", 16'h0020, 1'b1, 1'b0, 1'b0);
        ticks(2);
        observe();
        sb_push("prescaler_retained", 16'h0019, 1'b1, 1'b0, 1'b0);
        ticks(1);
        observe();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'bx;
            compared++;
            if (o !== e.value) begin
                mismatched++;
                $display("[TB] FAIL %s: got digits=%h flags=%b expected digits=%h flags=%b",
                         e.name, o[18:3], o[2:0], e.value[18:3], e.value[2:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [18:0] o;
        preset(16'h9999);
        sb_push("load_beats_start", 16'h9999, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        observe();
        preset(16'hAF3B);
        sb_push("load_clamp", 16'h9939, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        observe();
        preset(16'h0030);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(9);
        sb_push("tick_and_pause", 16'h0029, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        observe();
        preset(16'h0001);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(9);
        sb_push("expiry_beats_pause", 16'h0000, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        observe();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'bx;
            compared++;
            if (o !== e.value) begin
                mismatched++;
                $display("[TB] FAIL %s: got digits=%h flags=%b expected digits=%h flags=%b",
                         e.name, o[18:3], o[2:0], e.value[18:3], e.value[2:0]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t        e;
        logic [18:0] o;
        preset(16'h0555);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        sb_push("mid_run_value", 16'h0553, 1'b1, 1'b0, 1'b0);
        ticks(25);
        observe();
        sb_push("reset_mid_run", 16'h0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        observe();
        sb_push("start_at_zero", 16'h0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        observe();
        sb_push("zero_stays_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
        ticks(12);
        observe();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 19'bx;
            compared++;
            if (o !== e.value) begin
                mismatched++;
                $display("[TB] FAIL %s: got digits=%h flags=%b expected digits=%h flags=%b",
                         e.name, o[18:3], o[2:0], e.value[18:3], e.value[2:0]);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        tick_en     = 1'b0;
        load        = 1'b0;
        start_pause = 1'b0;
        preset(16'h0000);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] starting countdown_timer scenarios");
        test_reset();
        test_expiry();
        test_borrow_chain();
        test_pause_resume();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
